// File: rtl/cache_pkg.sv
// Shared types and defaults for the 2-way set-associative cache lookup/replacement controller.
package cache_pkg;

    localparam int WAYS        = 2;
    localparam int DEF_INDEX_W = 5;
    localparam int DEF_TAG_W   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_FILL,
        ST_RESP,
        ST_FLUSH
    } state_e;

endpackage

// File: rtl/cache_tag_way.sv
// One cache way: tag array plus valid bits, single write port, combinational read,
// and a one-cycle clear of every valid bit.
module cache_tag_way
    import cache_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int TAG_W   = DEF_TAG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_all_i,
    input  logic               wr_en_i,
    input  logic [INDEX_W-1:0] wr_index_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [INDEX_W-1:0] rd_index_i,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic               rd_valid_o
);

    localparam int NUM_SETS = 1 << INDEX_W;

    logic [NUM_SETS-1:0] valid_q;
    logic [TAG_W-1:0]    tag_q [NUM_SETS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (clear_all_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    // Tags need no reset: a line is only trusted when its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_index_i] <= wr_tag_i;
        end
    end

    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_valid_o = valid_q[rd_index_i];

endmodule

// File: rtl/cache_way_ctrl.sv
// Lookup/replacement controller for a 2-way set-associative cache: hit/miss
// resolution, LRU victim choice, miss-fill handshake and registered response.
module cache_way_ctrl
    import cache_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int TAG_W   = DEF_TAG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [INDEX_W-1:0] req_index,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               mem_req,
    output logic [INDEX_W-1:0] mem_index,
    output logic [TAG_W-1:0]   mem_tag,
    input  logic               mem_ack,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_hit,
    output logic               way_sel
);

    localparam int NUM_SETS = 1 << INDEX_W;

    state_e               state_q, state_d;
    logic [INDEX_W-1:0]   idx_q, idx_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic                 victim_q, victim_d;
    logic [NUM_SETS-1:0]  lru_q, lru_d;
    logic                 req_ready_q, req_ready_d;
    logic                 mem_req_q, mem_req_d;
    logic [INDEX_W-1:0]   mem_index_q, mem_index_d;
    logic [TAG_W-1:0]     mem_tag_q, mem_tag_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 resp_hit_q, resp_hit_d;
    logic                 way_sel_q, way_sel_d;

    logic [WAYS-1:0]      way_valid;
    logic [TAG_W-1:0]     way_tag [WAYS];
    logic [WAYS-1:0]      way_hit;
    logic                 hit_way;
    logic                 fill_we;
    logic                 clear_all;

    assign fill_we   = (state_q == ST_FILL) && mem_ack;
    assign clear_all = (state_q == ST_FLUSH);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_tag_way #(
            .INDEX_W (INDEX_W),
            .TAG_W   (TAG_W)
        ) u_way (
            .clk         (clk),
            .rst         (rst),
            .clear_all_i (clear_all),
            .wr_en_i     (fill_we && (victim_q == 1'(w))),
            .wr_index_i  (idx_q),
            .wr_tag_i    (tag_q),
            .rd_index_i  (idx_q),
            .rd_tag_o    (way_tag[w]),
            .rd_valid_o  (way_valid[w])
        );
        assign way_hit[w] = way_valid[w] && (way_tag[w] == tag_q);
    end

    // Way0 wins if both ways ever match the same tag.
    assign hit_way = ~way_hit[0];

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tag_d        = tag_q;
        victim_d     = victim_q;
        lru_d        = lru_q;
        req_ready_d  = req_ready_q;
        mem_req_d    = mem_req_q;
        mem_index_d  = mem_index_q;
        mem_tag_d    = mem_tag_q;
        resp_valid_d = resp_valid_q;
        resp_hit_d   = resp_hit_q;
        way_sel_d    = way_sel_q;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (flush) begin
                    state_d     = ST_FLUSH;
                    req_ready_d = 1'b0;
                end else if (req_valid && req_ready_q) begin
                    idx_d       = req_index;
                    tag_d       = req_tag;
                    state_d     = ST_LOOKUP;
                    req_ready_d = 1'b0;
                end
            end
            ST_LOOKUP: begin
                if (|way_hit) begin
                    way_sel_d      = hit_way;
                    resp_hit_d     = 1'b1;
                    resp_valid_d   = 1'b1;
                    lru_d[idx_q]   = ~hit_way;
                    state_d        = ST_RESP;
                end else begin
                    // Fill an empty way first; only evict by LRU when the set is full.
                    if (!way_valid[0]) begin
                        victim_d = 1'b0;
                    end else if (!way_valid[1]) begin
                        victim_d = 1'b1;
                    end else begin
                        victim_d = lru_q[idx_q];
                    end
                    mem_req_d   = 1'b1;
                    mem_index_d = idx_q;
                    mem_tag_d   = tag_q;
                    state_d     = ST_FILL;
                end
            end
            ST_FILL: begin
                if (mem_ack) begin
                    mem_req_d    = 1'b0;
                    lru_d[idx_q] = ~victim_q;
                    way_sel_d    = victim_q;
                    resp_hit_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                lru_d       = '0;
                req_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            lru_q        <= '0;
            req_ready_q  <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_index_q  <= '0;
            mem_tag_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            way_sel_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lru_q        <= lru_d;
            req_ready_q  <= req_ready_d;
            mem_req_q    <= mem_req_d;
            mem_index_q  <= mem_index_d;
            mem_tag_q    <= mem_tag_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            way_sel_q    <= way_sel_d;
        end
    end

    always_ff @(posedge clk) begin
        idx_q    <= idx_d;
        tag_q    <= tag_d;
        victim_q <= victim_d;
    end

    assign req_ready  = req_ready_q;
    assign mem_req    = mem_req_q;
    assign mem_index  = mem_index_q;
    assign mem_tag    = mem_tag_q;
    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;
    assign way_sel    = way_sel_q;

endmodule

// File: tb/tb_cache_way_ctrl.sv
// Scoreboard bench for cache_way_ctrl: directed scenarios then random traffic
// against a set-level behavioural model of the 2-way cache.
module tb_cache_way_ctrl;

    localparam int INDEX_W = 5;
    localparam int TAG_W   = 5;
    localparam int NSETS   = 1 << INDEX_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               req_valid;
    logic               req_ready;
    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic               mem_req;
    logic [INDEX_W-1:0] mem_index;
    logic [TAG_W-1:0]   mem_tag;
    logic               mem_ack;
    logic               resp_valid;
    logic               resp_ready;
    logic               resp_hit;
    logic               way_sel;

    cache_way_ctrl #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_index  (req_index),
        .req_tag    (req_tag),
        .mem_req    (mem_req),
        .mem_index  (mem_index),
        .mem_tag    (mem_tag),
        .mem_ack    (mem_ack),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_hit   (resp_hit),
        .way_sel    (way_sel)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit hit;
        bit way;
    } exp_t;
    exp_t sb[$];

    // Behavioural cache contents: which tag lives where, and which way is older.
    bit           mv   [2][NSETS];
    bit [TAG_W-1:0] mt [2][NSETS];
    bit           mlru [NSETS];

    bit exp_fill_valid = 0;
    int exp_fill_idx   = 0;
    int exp_fill_tag   = 0;
    int cur_fill_idx   = 0;
    int cur_fill_tag   = 0;
    int acc_cyc        = 0;
    bit force_stall    = 0;
    bit ack_en         = 1;
    int stall_seen     = 0;

    bit mon_prev_v = 0;
    bit rsp_seen   = 0;
    bit rsp_acked  = 0;
    int rsp_dly    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int s = 0; s < NSETS; s++) begin
            mv[0][s] = 0;
            mv[1][s] = 0;
            mlru[s]  = 0;
        end
    endfunction

    function automatic void model_access(input int idx, input int tag,
                                         output bit hit, output bit way);
        bit [TAG_W-1:0] t;
        t = tag[TAG_W-1:0];
        if (mv[0][idx] && mt[0][idx] == t) begin
            hit = 1; way = 0;
        end else if (mv[1][idx] && mt[1][idx] == t) begin
            hit = 1; way = 1;
        end else begin
            hit = 0;
            if (!mv[0][idx])      way = 0;
            else if (!mv[1][idx]) way = 1;
            else                  way = mlru[idx];
            mt[way][idx] = t;
            mv[way][idx] = 1;
        end
        mlru[idx] = !way;
    endfunction

    task automatic issue(input int idx, input int tag);
        bit h, w;
        exp_t e;
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 0, 1);
            return;
        end
        model_access(idx, tag, h, w);
        e.hit = h;
        e.way = w;
        sb.push_back(e);
        if (!h) begin
            exp_fill_valid = 1;
            exp_fill_idx   = idx;
            exp_fill_tag   = tag;
        end
        req_index = idx[INDEX_W-1:0];
        req_tag   = tag[TAG_W-1:0];
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic do_flush(input bit with_req, input int idx, input int tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        flush     = 1'b1;
        req_valid = with_req;
        req_index = idx[INDEX_W-1:0];
        req_tag   = tag[TAG_W-1:0];
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        model_clear();
    endtask

    // Consumer handshake: random backpressure unless a stall is forced.
    initial begin
        resp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            resp_ready = force_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Next-level memory: checks the fill request, acks after a random delay,
    // and throws in stray acks while no fill is pending.
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (rsp_acked) begin
                chk("miss_resp_latency", resp_valid, 1);
                rsp_acked = 0;
            end
            if (rst) begin
                rsp_seen = 0;
            end else if (mem_req) begin
                if (!rsp_seen) begin
                    rsp_seen = 1;
                    rsp_dly  = $urandom_range(0, 3);
                    if (!exp_fill_valid) begin
                        chk("unexpected_mem_req", 1, 0);
                    end else begin
                        chk("mem_index", mem_index, exp_fill_idx);
                        chk("mem_tag", mem_tag, exp_fill_tag);
                        cur_fill_idx   = exp_fill_idx;
                        cur_fill_tag   = exp_fill_tag;
                        exp_fill_valid = 0;
                    end
                end else begin
                    chk("mem_index_hold", mem_index, cur_fill_idx);
                    chk("mem_tag_hold", mem_tag, cur_fill_tag);
                end
                if (ack_en) begin
                    if (rsp_dly == 0) begin
                        mem_ack   = 1'b1;
                        rsp_acked = 1;
                    end else begin
                        rsp_dly--;
                    end
                end
            end else begin
                rsp_seen = 0;
                mem_ack  = ($urandom_range(0, 7) == 0);
            end
        end
    end

    // Response monitor: every visible response cycle is compared with the head entry.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_prev_v = 0;
            end else if (resp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else begin
                    chk("resp_hit", resp_hit, sb[0].hit);
                    chk("way_sel", way_sel, sb[0].way);
                    chk("req_ready_during_resp", req_ready, 0);
                    if (!mon_prev_v && sb[0].hit)
                        chk("hit_latency", cyc - acc_cyc, 1);
                    if (resp_ready) void'(sb.pop_front());
                    else stall_seen++;
                end
                mon_prev_v = !resp_ready;
            end else begin
                mon_prev_v = 0;
            end
        end
    end

    initial begin
        repeat (40000) @(posedge clk);
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int idx, tag;
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_index = '0;
        req_tag   = '0;
        model_clear();

        // Reset state
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_index", mem_index, 0);
        chk("rst_mem_tag", mem_tag, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_hit", resp_hit, 0);
        chk("rst_way_sel", way_sel, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("req_ready_after_rst", req_ready, 1);

        // Miss then hit on the same line, then LRU replacement within set 3
        issue(3, 'h0A); wait_done();
        issue(3, 'h0A); wait_done();
        issue(3, 'h0B); wait_done();
        issue(3, 'h0C); wait_done();
        issue(3, 'h0B); wait_done();

        // Consumer stalls with a response pending
        stall_seen  = 0;
        force_stall = 1;
        issue(3, 'h0B);
        repeat (8) @(negedge clk);
        force_stall = 0;
        wait_done();
        chk("stall_cycles_seen", int'(stall_seen >= 5), 1);

        // Reset while a fill is outstanding
        ack_en = 0;
        issue(3, 'h0D);
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fill_reached", mem_req, 1);
        #1 rst = 1'b1;
        #1;
        chk("mem_req_drop_on_rst", mem_req, 0);
        chk("req_ready_in_rst", req_ready, 0);
        chk("resp_valid_in_rst", resp_valid, 0);
        sb.delete();
        exp_fill_valid = 0;
        model_clear();
        @(negedge clk);
        rst    = 1'b0;
        ack_en = 1;
        issue(3, 'h0B); wait_done();

        // Flush beats a simultaneous request
        do_flush(1, 3, 'h0B);
        @(negedge clk);
        chk("req_ready_in_flush", req_ready, 0);
        chk("no_resp_after_flush", resp_valid, 0);
        @(negedge clk);
        chk("req_ready_after_flush", req_ready, 1);
        issue(3, 'h0B); wait_done();

        // Random traffic concentrated on a few sets to force hits and evictions
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                do_flush(0, 0, 0);
            end else begin
                idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NSETS - 1))
                                                  : int'($urandom_range(0, 3));
                tag = $urandom_range(0, 5);
                issue(idx, tag);
            end
        end
        wait_done();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
